string_accel_core: RTL and testbench

//  Parametrised successor to the fixed 8-char string accelerator behind the Avalon register file.

---
 rtl/string_accel_pkg.sv | 34 +++
 rtl/string_accel_if.sv | 31 +++
 rtl/string_lane_xform.sv | 29 ++
 rtl/string_accel_core.sv | 196 +++++++++++++++++++
 tb/tb_string_accel_core.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/string_accel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : string_accel_pkg
// Description : Shared types, constants and the lane-select helper for the
//               string accelerator.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package string_accel_pkg;

    typedef enum logic [3:0] {
        OP_CMP    = 4'd0,
        OP_UPPER  = 4'd1,
        OP_LOWER  = 4'd2,
        OP_STRLEN = 4'd3,
        OP_REV    = 4'd4
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [7:0] CHAR_NUL   = 8'h00;
    localparam logic [7:0] CASE_DELTA = 8'd32;

    // Byte position handled by a given lane during a given beat.
    function automatic int lane_sel(input int beat, input int lane, input int lanes);
        return beat * lanes + lane;
    endfunction

endpackage
`default_nettype wire

// File: rtl/string_accel_if.sv
`default_nettype none
// ============================================================================
// Module      : string_accel_if
// Description : Control/operand/result bundle between the register file and
//               the string accelerator core.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
interface string_accel_if #(
    parameter int NCHARS = 16
);
    logic                     go;
    logic [3:0]               index;
    logic [0:NCHARS-1][7:0]   A;
    logic [0:NCHARS-1][7:0]   B;
    logic                     busy;
    logic                     done;
    logic                     err;
    logic [31:0]              value;
    logic [0:NCHARS-1][7:0]   Result;

    modport master (
        output go, index, A, B,
        input  busy, done, err, value, Result
    );

    modport slave (
        input  go, index, A, B,
        output busy, done, err, value, Result
    );
endinterface
`default_nettype wire

// File: rtl/string_lane_xform.sv
`default_nettype none
// ============================================================================
// Module      : string_lane_xform
// Description : Single-character case converter with NUL detect; one
//               instance per processing lane.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module string_lane_xform
    import string_accel_pkg::*;
(
    input  logic [7:0] i_char,
    input  op_e        i_op,
    output logic [7:0] o_char,
    output logic       o_is_nul
);

    always_comb begin
        o_char = i_char;
        case (i_op)
            OP_UPPER: if (i_char >= 8'h61 && i_char <= 8'h7A) o_char = i_char - CASE_DELTA;
            OP_LOWER: if (i_char >= 8'h41 && i_char <= 8'h5A) o_char = i_char + CASE_DELTA;
            default:  o_char = i_char;
        endcase
    end

    assign o_is_nul = (i_char == CHAR_NUL);

endmodule
`default_nettype wire

// File: rtl/string_accel_core.sv
`default_nettype none
// ============================================================================
// Module      : string_accel_core
// Description : Multi-beat string engine (cmp/upper/lower/strlen, LANES
//               chars per beat). Optional reverse op: STRING_ACCEL_REVERSE_EN.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module string_accel_core
    import string_accel_pkg::*;
#(
    parameter int NCHARS = 16,
    parameter int LANES  = 4
) (
    input  logic              clk,
    input  logic              reset,
    string_accel_if.slave     bus
);

    localparam int BEATS = NCHARS / LANES;
    localparam int BW    = $clog2(BEATS) + 1;
    localparam int IW    = (NCHARS > 1) ? $clog2(NCHARS) : 1;

    state_e                  state_q, state_d;
    logic [BW-1:0]           beat_q, beat_d;
    op_e                     op_q, op_d;
    logic [0:NCHARS-1][7:0]  a_q, a_d, b_q, b_d, result_q, result_d;
    logic [31:0]             value_q, value_d;
    logic                    err_q, err_d;
    logic                    hit;
    logic                    w_last;
    logic                    w_op_ok;
    logic [IW-1:0]           w_idx      [LANES];
    logic [7:0]              w_lane_out [LANES];
    logic                    w_lane_nul [LANES];

`ifdef STRING_ACCEL_REVERSE_EN
    localparam int LW = IW + 1;
    logic                    pass_q, pass_d;
    logic                    found_q, found_d;
    logic [LW-1:0]           len_q, len_d;
    int                      src;
    assign w_op_ok = (bus.index <= 4'd4);
`else
    assign w_op_ok = (bus.index <= 4'd3);
`endif

    assign w_last = (beat_q == BW'(BEATS - 1));

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_idx[l] = IW'(lane_sel(int'(beat_q), l, LANES));
        string_lane_xform u_xform (
            .i_char   (a_q[w_idx[l]]),
            .i_op     (op_q),
            .o_char   (w_lane_out[l]),
            .o_is_nul (w_lane_nul[l])
        );
    end

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        value_d  = value_q;
        err_d    = err_q;
        hit      = 1'b0;
`ifdef STRING_ACCEL_REVERSE_EN
        pass_d   = pass_q;
        found_d  = found_q;
        len_d    = len_q;
        src      = 0;
`endif
        case (state_q)
            ST_IDLE: if (bus.go) state_d = ST_LOAD;
            ST_LOAD: begin
                a_d      = bus.A;
                b_d      = bus.B;
                op_d     = op_e'(bus.index);
                result_d = '0;
                value_d  = '0;
                err_d    = !w_op_ok;
                beat_d   = '0;
`ifdef STRING_ACCEL_REVERSE_EN
                pass_d   = 1'b0;
                found_d  = 1'b0;
                len_d    = '0;
`endif
                state_d  = w_op_ok ? ST_RUN : ST_DONE;
            end
            ST_RUN: begin
                beat_d = beat_q + BW'(1);
                case (op_q)
                    OP_UPPER, OP_LOWER: begin
                        for (int l = 0; l < LANES; l++) result_d[w_idx[l]] = w_lane_out[l];
                        if (w_last) state_d = ST_DONE;
                    end
                    // Lowest lane that differs or hits NUL decides the beat.
                    OP_CMP: begin
                        for (int l = 0; l < LANES; l++) begin
                            if (!hit) begin
                                if (a_q[w_idx[l]] != b_q[w_idx[l]]) begin
                                    hit     = 1'b1;
                                    value_d = (a_q[w_idx[l]] < b_q[w_idx[l]]) ? 32'hFFFF_FFFF : 32'd1;
                                end else if (w_lane_nul[l]) begin
                                    hit     = 1'b1;
                                    value_d = '0;
                                end
                            end
                        end
                        if (hit || w_last) state_d = ST_DONE;
                    end
                    OP_STRLEN: begin
                        for (int l = 0; l < LANES; l++) begin
                            if (!hit && w_lane_nul[l]) begin
                                hit     = 1'b1;
                                value_d = 32'(w_idx[l]);
                            end
                        end
                        if (!hit && w_last) value_d = 32'(NCHARS);
                        if (hit || w_last) state_d = ST_DONE;
                    end
`ifdef STRING_ACCEL_REVERSE_EN
                    // Pass 0 measures the length over all beats; pass 1 writes the mirror.
                    OP_REV: begin
                        if (!pass_q) begin
                            for (int l = 0; l < LANES; l++) begin
                                if (!found_q && !hit && w_lane_nul[l]) begin
                                    hit   = 1'b1;
                                    len_d = LW'(w_idx[l]);
                                end
                            end
                            if (hit) found_d = 1'b1;
                            if (w_last) begin
                                pass_d = 1'b1;
                                beat_d = '0;
                                if (!found_q && !hit) len_d = LW'(NCHARS);
                            end
                        end else begin
                            for (int l = 0; l < LANES; l++) begin
                                src = int'(len_q) - 1 - int'(w_idx[l]);
                                result_d[w_idx[l]] = (int'(w_idx[l]) < int'(len_q)) ? a_q[IW'(src)] : CHAR_NUL;
                            end
                            if (w_last) state_d = ST_DONE;
                        end
                    end
`endif
                    default: state_d = ST_DONE;
                endcase
            end
            ST_DONE: if (!bus.go) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            beat_q   <= '0;
            op_q     <= OP_CMP;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            value_q  <= '0;
            err_q    <= 1'b0;
`ifdef STRING_ACCEL_REVERSE_EN
            pass_q   <= 1'b0;
            found_q  <= 1'b0;
            len_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            value_q  <= value_d;
            err_q    <= err_d;
`ifdef STRING_ACCEL_REVERSE_EN
            pass_q   <= pass_d;
            found_q  <= found_d;
            len_q    <= len_d;
`endif
        end
    end

    assign bus.busy   = (state_q == ST_LOAD) || (state_q == ST_RUN);
    assign bus.done   = (state_q == ST_DONE);
    assign bus.err    = err_q;
    assign bus.value  = value_q;
    assign bus.Result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_string_accel_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_string_accel_core
// Description : Scoreboard bench for string_accel_core (NCHARS=16, LANES=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_string_accel_core;

    localparam int NCHARS = 16;
    localparam int LANES  = 4;
    localparam int BEATS  = NCHARS / LANES;

    typedef logic [0:NCHARS-1][7:0] str_t;
    typedef struct {
        logic [31:0] value;
        str_t        result;
        logic        err;
        int          busy;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   fails  = 0;
    exp_t sb[$];

    string_accel_if #(.NCHARS(NCHARS)) bus_if ();

    string_accel_core #(.NCHARS(NCHARS), .LANES(LANES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [NCHARS*8-1:0] act, input logic [NCHARS*8-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic str_t mk(input string s);
        str_t r = '0;
        for (int i = 0; i < s.len() && i < NCHARS; i++) r[i] = s[i];
        return r;
    endfunction

    function automatic str_t rnd_str();
        str_t r = '0;
        int   n = $urandom_range(0, NCHARS);
        for (int i = 0; i < n; i++) r[i] = 8'($urandom_range(33, 122));
        return r;
    endfunction

    // Reference: busy counts LOAD plus RUN cycles that precede done.
    function automatic exp_t model(input int idx, input str_t a, input str_t b);
        exp_t e;
        int   len;
        e.value  = '0;
        e.result = '0;
        e.err    = 1'b0;
        e.busy   = 1 + BEATS;
        len = NCHARS;
        for (int i = NCHARS - 1; i >= 0; i--) if (a[i] == 8'h00) len = i;
        case (idx)
            0: begin
                for (int i = 0; i < NCHARS; i++) begin
                    if (a[i] != b[i] || a[i] == 8'h00) begin
                        if (a[i] < b[i]) e.value = 32'hFFFF_FFFF;
                        else if (a[i] > b[i]) e.value = 32'd1;
                        e.busy = 2 + i / LANES;
                        break;
                    end
                end
            end
            1: for (int i = 0; i < NCHARS; i++)
                   e.result[i] = (a[i] >= 8'h61 && a[i] <= 8'h7A) ? a[i] - 8'd32 : a[i];
            2: for (int i = 0; i < NCHARS; i++)
                   e.result[i] = (a[i] >= 8'h41 && a[i] <= 8'h5A) ? a[i] + 8'd32 : a[i];
            3: begin
                e.value = 32'(len);
                if (len < NCHARS) e.busy = 2 + len / LANES;
            end
`ifdef STRING_ACCEL_REVERSE_EN
            4: begin
                for (int i = 0; i < len; i++) e.result[i] = a[len - 1 - i];
                e.busy = 1 + 2 * BEATS;
            end
`endif
            default: begin
                e.err  = 1'b1;
                e.busy = 1;
            end
        endcase
        return e;
    endfunction

    task automatic run_op(input int idx, input str_t a, input str_t b, input int hold);
        int n;
        @(posedge clk); #1;
        bus_if.index = 4'(idx);
        bus_if.A     = a;
        bus_if.B     = b;
        bus_if.go    = 1'b1;
        sb.push_back(model(idx, a, b));
        @(posedge clk);
        @(posedge clk); #1;
        for (int i = 0; i < NCHARS; i++) begin
            bus_if.A[i] = 8'($urandom);
            bus_if.B[i] = 8'($urandom);
        end
        bus_if.index = 4'($urandom);
        n = 0;
        while (!bus_if.done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus_if.done) begin
            checks++;
            fails++;
            $display("FAIL done_timeout: got done=0 expected done=1 op=%0d", idx);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("done_held", bus_if.done, 1'b1);
            chk("no_restart", bus_if.busy, 1'b0);
        end
        bus_if.go = 1'b0;
        @(posedge clk); #1;
        chk("done_fall", bus_if.done, 1'b0);
    endtask

    // Monitor: pops one expectation per rising edge of done.
    int   busy_cnt = 0;
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            busy_cnt  = 0;
            done_prev = 1'b0;
        end else begin
            if (bus_if.busy) busy_cnt++;
            if (bus_if.done && !done_prev) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_done: got done=1 expected no result pending");
                end else begin
                    e = sb.pop_front();
                    chk("value", bus_if.value, e.value);
                    chk("result", bus_if.Result, e.result);
                    chk("err", bus_if.err, e.err);
                    chk("latency", busy_cnt, e.busy);
                end
                busy_cnt = 0;
            end
            done_prev = bus_if.done;
        end
    end

    initial begin
        str_t a, b;
        int   idx;
        reset        = 1'b1;
        bus_if.go    = 1'b0;
        bus_if.index = '0;
        bus_if.A     = '0;
        bus_if.B     = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_busy", bus_if.busy, 1'b0);
        chk("rst_done", bus_if.done, 1'b0);
        chk("rst_err", bus_if.err, 1'b0);
        chk("rst_value", bus_if.value, 32'd0);
        chk("rst_result", bus_if.Result, '0);

        run_op(1, mk("hello World!"), '0, 0);
        run_op(0, mk("abc"), mk("abc"), 0);
        run_op(0, mk("abd"), mk("abc"), 0);
        run_op(0, mk("abc"), mk("abd"), 0);
        run_op(3, mk("ABCDEFGHIJKLMNOP"), '0, 0);
        run_op(3, '0, '0, 0);
        run_op(2, mk("MiXeD CaSe @[`{"), '0, 1);
        run_op(0, mk("ABCDEFGHIJKLMNOP"), mk("ABCDEFGHIJKLMNOP"), 0);
        run_op(7, mk("abc"), '0, 10);
        run_op(4, mk("abc"), '0, 0);
        run_op(4, mk("ABCDEFGHIJKLMNOP"), '0, 0);

        for (int t = 0; t < 40; t++) begin
            a = rnd_str();
            b = a;
            if ($urandom_range(0, 1) == 1) b[$urandom_range(0, NCHARS - 1)] = 8'($urandom_range(0, 127));
            idx = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 15) : $urandom_range(0, 4);
            run_op(idx, a, b, $urandom_range(0, 3));
        end

        // Abort a lowercase op after its first RUN beat has written Result.
        @(posedge clk); #1;
        bus_if.index = 4'd2;
        bus_if.A     = mk("HELLO WORLD!");
        bus_if.go    = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset     = 1'b0;
        bus_if.go = 1'b0;
        chk("abort_busy", bus_if.busy, 1'b0);
        chk("abort_done", bus_if.done, 1'b0);
        chk("abort_err", bus_if.err, 1'b0);
        chk("abort_value", bus_if.value, 32'd0);
        chk("abort_result", bus_if.Result, '0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_idle", bus_if.busy, 1'b0);
        chk("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
